// File: rtl/cbs_pkg.sv
// Shared types and constants for the credit-based shaper.
// Optional macro CBS_HICREDIT_CLAMP_EN enables the hi_credit ceiling in cbs_credit_counter.
package cbs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } cbs_state_e;

    localparam int unsigned CBS_CREDIT_WIDTH = 32;
    localparam int unsigned CBS_SLOPE_WIDTH  = 16;

    localparam logic signed [CBS_CREDIT_WIDTH-1:0] CBS_CREDIT_MAX = {1'b0, {(CBS_CREDIT_WIDTH-1){1'b1}}};
    localparam logic signed [CBS_CREDIT_WIDTH-1:0] CBS_CREDIT_MIN = {1'b1, {(CBS_CREDIT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/cbs_credit_counter.sv
// Saturating signed credit accumulator with subtract > zero > add priority.
// CBS_HICREDIT_CLAMP_EN: when defined, every increase is capped at hi_credit.
module cbs_credit_counter
    import cbs_pkg::*;
#(
    parameter int unsigned CREDIT_WIDTH = CBS_CREDIT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           add_en,
    input  logic                           sub_en,
    input  logic                           zero_en,
    input  logic [CBS_SLOPE_WIDTH-1:0]     add_amt,
    input  logic [CBS_SLOPE_WIDTH-1:0]     sub_amt,
    input  logic signed [CREDIT_WIDTH-1:0] hi_credit,
    output logic signed [CREDIT_WIDTH-1:0] credit
);

    localparam int unsigned EXT_WIDTH = CREDIT_WIDTH + 1;
    localparam logic signed [CREDIT_WIDTH-1:0] CREDIT_MAX = {1'b0, {(CREDIT_WIDTH-1){1'b1}}};
    localparam logic signed [CREDIT_WIDTH-1:0] CREDIT_MIN = {1'b1, {(CREDIT_WIDTH-1){1'b0}}};

    logic signed [EXT_WIDTH-1:0]    credit_ext;
    logic signed [EXT_WIDTH-1:0]    add_ext;
    logic signed [EXT_WIDTH-1:0]    sub_ext;
    logic signed [EXT_WIDTH-1:0]    sum_ext;
    logic signed [EXT_WIDTH-1:0]    diff_ext;
    logic signed [CREDIT_WIDTH-1:0] up_val;
    logic signed [CREDIT_WIDTH-1:0] down_val;
    logic signed [CREDIT_WIDTH-1:0] credit_nxt;

    // One extra bit of headroom makes a single 16-bit step overflow-free.
    always_comb begin
        credit_ext = $signed({credit[CREDIT_WIDTH-1], credit});
        add_ext    = $signed({{(EXT_WIDTH-CBS_SLOPE_WIDTH){1'b0}}, add_amt});
        sub_ext    = $signed({{(EXT_WIDTH-CBS_SLOPE_WIDTH){1'b0}}, sub_amt});
        sum_ext    = credit_ext + add_ext;
        diff_ext   = credit_ext - sub_ext;

        if (sum_ext > $signed({CREDIT_MAX[CREDIT_WIDTH-1], CREDIT_MAX})) begin
            up_val = CREDIT_MAX;
        end else begin
            up_val = CREDIT_WIDTH'(sum_ext);
        end
`ifdef CBS_HICREDIT_CLAMP_EN
        // Never pull an already-high credit down on an increase step.
        if (up_val > hi_credit) begin
            up_val = (credit > hi_credit) ? credit : hi_credit;
        end
`endif

        if (diff_ext < $signed({CREDIT_MIN[CREDIT_WIDTH-1], CREDIT_MIN})) begin
            down_val = CREDIT_MIN;
        end else begin
            down_val = CREDIT_WIDTH'(diff_ext);
        end

        credit_nxt = credit;
        if (sub_en) begin
            credit_nxt = down_val;
        end else if (zero_en) begin
            credit_nxt = '0;
        end else if (add_en) begin
            credit_nxt = up_val;
        end
    end

`ifndef CBS_HICREDIT_CLAMP_EN
    logic unused_hi_credit;
    assign unused_hi_credit = ^hi_credit;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit <= '0;
        end else begin
            credit <= credit_nxt;
        end
    end

endmodule

// File: rtl/cbs_credit_shaper.sv
// 802.1Qav-style credit-based shaper gating frame starts on one AXI4-Stream queue.
// Optional macro CBS_HICREDIT_CLAMP_EN caps credit growth at hi_credit.
module cbs_credit_shaper
    import cbs_pkg::*;
#(
    parameter int unsigned CREDIT_WIDTH = CBS_CREDIT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [15:0]                    idle_slope,
    input  logic [15:0]                    send_slope,
    input  logic signed [CREDIT_WIDTH-1:0] hi_credit,
    input  logic [7:0]                     s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tuser,
    output logic [7:0]                     m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    output logic signed [CREDIT_WIDTH-1:0] credit
);

    cbs_state_e state;
    cbs_state_e state_nxt;
    logic       eligible;
    logic       accept;
    logic       add_en;
    logic       sub_en;
    logic       zero_en;

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tlast = s_axis_tlast;
    assign m_axis_tuser = s_axis_tuser;
    assign eligible     = ~credit[CREDIT_WIDTH-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake gating, frame tracking and credit-update selection.
    always_comb begin
        state_nxt     = state;
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        accept        = 1'b0;
        add_en        = 1'b0;
        sub_en        = 1'b0;
        zero_en       = 1'b0;

        case (state)
            IDLE: begin
                m_axis_tvalid = s_axis_tvalid & eligible & rstn;
                s_axis_tready = m_axis_tready & eligible & rstn;
            end
            SEND: begin
                m_axis_tvalid = s_axis_tvalid & rstn;
                s_axis_tready = m_axis_tready & rstn;
            end
            default: ;
        endcase

        accept = s_axis_tvalid & s_axis_tready;

        if (accept) begin
            sub_en = 1'b1;
            if (state == IDLE && !s_axis_tlast) begin
                state_nxt = SEND;
            end else if (state == SEND && s_axis_tlast) begin
                state_nxt = IDLE;
            end
        end else if (state == IDLE) begin
            if (s_axis_tvalid || !eligible) begin
                add_en = 1'b1;
            end else if (|credit) begin
                zero_en = 1'b1;
            end
        end
    end

    cbs_credit_counter #(
        .CREDIT_WIDTH(CREDIT_WIDTH)
    ) u_credit_counter (
        .clk      (clk),
        .rstn     (rstn),
        .add_en   (add_en),
        .sub_en   (sub_en),
        .zero_en  (zero_en),
        .add_amt  (idle_slope),
        .sub_amt  (send_slope),
        .hi_credit(hi_credit),
        .credit   (credit)
    );

endmodule

// File: tb/tb_cbs_credit_shaper.sv
// Directed bench for cbs_credit_shaper at the minimum 18-bit credit width.
module tb_cbs_credit_shaper;

    localparam int unsigned CW = 18;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [15:0]          idle_slope;
    logic [15:0]          send_slope;
    logic signed [CW-1:0] hi_credit;
    logic [7:0]           s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic                 s_axis_tlast;
    logic                 s_axis_tuser;
    logic [7:0]           m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 m_axis_tuser;
    logic signed [CW-1:0] credit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cbs_credit_shaper #(.CREDIT_WIDTH(CW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .idle_slope   (idle_slope),
        .send_slope   (send_slope),
        .hi_credit    (hi_credit),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .credit       (credit)
    );

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #3;
        rstn = 1'b1;
        step();
    endtask

    initial begin
        rstn          = 1'b0;
        idle_slope    = 16'd1;
        send_slope    = 16'd3;
        hi_credit     = 18'sd10;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b1;

        // Reset holds handshake low and credit at zero.
        step();
        check_val("rst_mvalid", 32'(m_axis_tvalid), 0);
        check_val("rst_sready", 32'(s_axis_tready), 0);
        check_val("rst_credit", credit, 0);
        rstn = 1'b1;
        #1;

        // 4-beat frame at credit 0 with send_slope 3 leaves credit at -12.
        s_axis_tdata = 8'hA0;
        s_axis_tuser = 1'b1;
        #1;
        check_val("first_mvalid", 32'(m_axis_tvalid), 1);
        check_val("first_data", 32'(m_axis_tdata), 32'hA0);
        check_val("first_user", 32'(m_axis_tuser), 1);
        for (int i = 0; i < 4; i++) begin
            s_axis_tlast = (i == 3);
            s_axis_tdata = 8'(8'hA0 + i);
            #1;
            check_val("frame_tlast_out", 32'(m_axis_tlast), (i == 3) ? 1 : 0);
            step();
            check_val("frame_credit", credit, -3 * (i + 1));
        end
        s_axis_tlast = 1'b0;
        s_axis_tuser = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            check_val("blocked_mvalid", 32'(m_axis_tvalid), 0);
            check_val("blocked_credit", credit, -12 + i);
            step();
        end
        check_val("release_mvalid", 32'(m_axis_tvalid), 1);
        check_val("release_credit", credit, 0);
        s_axis_tvalid = 1'b0;
        step();
        check_val("empty_hold0", credit, 0);

        // Single-beat frame stays in IDLE; empty queue recovers -5 up to 0 and holds.
        send_slope    = 16'd5;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        step();
        check_val("single_credit", credit, -5);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("recover_credit", credit, (i < 5) ? (-4 + i) : 0);
        end

        // Blocked by the arbiter: credit grows, clamped at hi_credit when enabled.
        idle_slope    = 16'd4;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
`ifdef CBS_HICREDIT_CLAMP_EN
            check_val("grow_credit", credit, (4 * (i + 1) > 10) ? 10 : 4 * (i + 1));
`else
            check_val("grow_credit", credit, 4 * (i + 1));
`endif
            check_val("grow_mvalid", 32'(m_axis_tvalid), 1);
        end
        s_axis_tvalid = 1'b0;
        step();
        check_val("bank_zeroed", credit, 0);

        // Stalled frame: credit only drops on accepted beats; exits SEND on accepted tlast.
        idle_slope    = 16'd1;
        send_slope    = 16'd2;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        step();
        check_val("stall_credit1", credit, -2);
        s_axis_tlast  = 1'b1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_val("stall_send_mvalid", 32'(m_axis_tvalid), 1);
            check_val("stall_sready", 32'(s_axis_tready), 0);
            step();
            check_val("stall_credit_hold", credit, -2);
        end
        m_axis_tready = 1'b1;
        #1;
        check_val("stall_accept_sready", 32'(s_axis_tready), 1);
        step();
        check_val("stall_credit2", credit, -4);
        s_axis_tlast = 1'b0;
        #1;
        check_val("back_idle_mvalid", 32'(m_axis_tvalid), 0);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_val("stall_recovered", credit, 0);

        // Reset mid-frame: handshake drops asynchronously, first beat after passes.
        s_axis_tvalid = 1'b1;
        step();
        check_val("mid_credit", credit, -2);
        #1;
        check_val("mid_send_mvalid", 32'(m_axis_tvalid), 1);
        rstn = 1'b0;
        #1;
        check_val("async_mvalid", 32'(m_axis_tvalid), 0);
        check_val("async_sready", 32'(s_axis_tready), 0);
        check_val("async_credit", credit, 0);
        rstn = 1'b1;
        s_axis_tlast = 1'b1;
        #1;
        check_val("post_rst_mvalid", 32'(m_axis_tvalid), 1);
        check_val("post_rst_sready", 32'(s_axis_tready), 1);
        step();
        check_val("post_rst_credit", credit, -2);
        s_axis_tlast = 1'b0;
        #1;
        check_val("post_rst_idle", 32'(m_axis_tvalid), 0);

        // Saturation at the 18-bit signed minimum.
        s_axis_tvalid = 1'b0;
        do_reset();
        idle_slope    = 16'd0;
        send_slope    = 16'hFFFF;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("sat_credit", credit, (i == 0) ? -65535 : (i == 1) ? -131070 : -131072);
        end
        s_axis_tlast = 1'b1;
        step();
        check_val("sat_tlast_credit", credit, -131072);
        s_axis_tlast = 1'b0;
        step();
        check_val("sat_hold_credit", credit, -131072);
        check_val("sat_blocked", 32'(m_axis_tvalid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
